// File: rtl/wsn_medium_pkg.sv
// wsn_medium_pkg: shared constants and helpers for the air-medium model
package wsn_medium_pkg;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  function automatic int pop_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/wsn_delay_line.sv
// wsn_delay_line: DEPTH-stage WIDTH-bit shift register with synchronous reset
module wsn_delay_line #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] sr [DEPTH];
  always_ff @(posedge clk) begin
    if (reset) for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/wsn_air_medium.sv
// wsn_air_medium: delayed N-node radio medium with collisions, half-duplex masking and LFSR bit errors
module wsn_air_medium
  import wsn_medium_pkg::*;
#(
  parameter int          N_NODES   = 2,
  parameter int          DELAY     = 4,
  parameter int          BER_SHIFT = 0,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [N_NODES-1:0] tx_en,
  input  logic [N_NODES-1:0] antena_out,
  output logic [N_NODES-1:0] antena_in,
  output logic               collision,
  output logic [4:0]         active_cnt,
  output logic [CNT_W-1:0]   collision_cnt,
  output logic [CNT_W-1:0]   error_cnt
);
  localparam int PW = pop_w(N_NODES);
  localparam logic [15:0] SEED_EFF = (SEED == 16'd0) ? DEFAULT_SEED : SEED;
  localparam logic [15:0] BER_MASK = 16'((32'd1 << BER_SHIFT) - 32'd1);
  logic [1:0] stage [N_NODES];
  logic [N_NODES-1:0] d_en, d_bit;
  logic [PW-1:0] k;
  logic [15:0] lfsr;
  logic err, m, coll_nx;
  for (genvar i = 0; i < N_NODES; i++) begin : g_node
    wsn_delay_line #(.DEPTH(DELAY), .WIDTH(2)) u_dl (
      .clk(clk),
      .reset(reset),
      .d({tx_en[i], antena_out[i]}),
      .q(stage[i])
    );
    assign d_en[i] = stage[i][1];
    assign d_bit[i] = stage[i][0];
  end
  always_comb begin
    k = '0;
    for (int j = 0; j < N_NODES; j++) k = k + PW'(d_en[j]);
  end
  always_comb begin
    err = (BER_SHIFT > 0) && en && (k == PW'(1)) && ((lfsr & BER_MASK) == 16'd0);
    m = en && ((|(d_en & d_bit)) ^ err);
    coll_nx = en && (k >= PW'(2));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= SEED_EFF;
      antena_in <= '0;
      collision <= 1'b0;
      active_cnt <= '0;
      collision_cnt <= '0;
      error_cnt <= '0;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'd0);
      antena_in <= ~d_en & {N_NODES{m}};
      collision <= coll_nx;
      active_cnt <= en ? 5'(k) : 5'd0;
      if (coll_nx && !collision && !(&collision_cnt)) collision_cnt <= collision_cnt + CNT_W'(1);
      if (err && !(&error_cnt)) error_cnt <= error_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_wsn_air_medium.sv
// tb_wsn_air_medium: scoreboard bench for the radio-medium model
module tb_wsn_air_medium;
  localparam int N = 3;
  localparam int DL = 8;
  localparam int BER = 2;
  localparam int CW = 8;
  localparam logic [15:0] SD = 16'hACE1;
  typedef struct packed {
    logic [N-1:0]  ain;
    logic          coll;
    logic [4:0]    act;
    logic [CW-1:0] ccnt;
    logic [CW-1:0] ecnt;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic [N-1:0] tx_en = '0;
  logic [N-1:0] antena_out = '0;
  logic [N-1:0] antena_in;
  logic collision;
  logic [4:0] active_cnt;
  logic [CW-1:0] collision_cnt, error_cnt;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  logic [N-1:0] h_en [DL];
  logic [N-1:0] h_bit [DL];
  logic [15:0] m_lfsr;
  logic m_coll;
  logic [CW-1:0] m_ccnt, m_ecnt;
  wsn_air_medium #(
    .N_NODES(N), .DELAY(DL), .BER_SHIFT(BER), .SEED(SD), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .tx_en(tx_en),
    .antena_out(antena_out),
    .antena_in(antena_in),
    .collision(collision),
    .active_cnt(active_cnt),
    .collision_cnt(collision_cnt),
    .error_cnt(error_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  task automatic tick();
    exp_t e;
    int k;
    logic err, mv, any;
    if (reset) begin
      e = '0;
      for (int i = 0; i < DL; i++) begin
        h_en[i] = '0;
        h_bit[i] = '0;
      end
      m_lfsr = SD;
      m_coll = 1'b0;
      m_ccnt = '0;
      m_ecnt = '0;
    end else begin
      k = $countones(h_en[DL-1]);
      any = |(h_en[DL-1] & h_bit[DL-1]);
      err = en && (k == 1) && (m_lfsr[BER-1:0] == '0);
      mv = (!en || k == 0) ? 1'b0 : (k == 1) ? any ^ err : any;
      e.ain = ~h_en[DL-1] & {N{mv}};
      e.coll = en && (k >= 2);
      e.act = en ? 5'(k) : 5'd0;
      if (e.coll && !m_coll && m_ccnt != '1) m_ccnt++;
      if (err && m_ecnt != '1) m_ecnt++;
      m_coll = e.coll;
      e.ccnt = m_ccnt;
      e.ecnt = m_ecnt;
      for (int i = DL - 1; i > 0; i--) begin
        h_en[i] = h_en[i-1];
        h_bit[i] = h_bit[i-1];
      end
      h_en[0] = tx_en;
      h_bit[0] = antena_out;
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("antena_in", 32'(antena_in), 32'(e.ain));
    check("collision", 32'(collision), 32'(e.coll));
    check("active_cnt", 32'(active_cnt), 32'(e.act));
    check("collision_cnt", 32'(collision_cnt), 32'(e.ccnt));
    check("error_cnt", 32'(error_cnt), 32'(e.ecnt));
  endtask
  task automatic do_reset();
    tx_en = '0;
    antena_out = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask
  task automatic overlap();
    for (int j = 0; j < DL + 12; j++) begin
      tx_en = (j < 10) ? 3'b011 : 3'b000;
      antena_out = (j < 10) ? 3'b010 : 3'b000;
      tick();
      if (j >= DL && j < DL + 10) begin
        check("ovl_ain2", 32'(antena_in[2]), 32'd1);
        check("ovl_coll", 32'(collision), 32'd1);
        check("ovl_act", 32'(active_cnt), 32'd2);
      end
    end
  endtask
  initial begin
    logic [3:0] pat;
    pat = 4'b1011;
    reset = 1'b1;
    tick();
    tick();
    check("rst_ain", 32'(antena_in), 32'd0);
    check("rst_ccnt", 32'(collision_cnt), 32'd0);
    reset = 1'b0;
    en = 1'b1;
    for (int j = 0; j < DL + 6; j++) begin
      tx_en = (j < 4) ? 3'b001 : 3'b000;
      antena_out = (j < 4) ? {2'b00, pat[3-j]} : 3'b000;
      tick();
      check("t1_ain0", 32'(antena_in[0]), 32'd0);
      check("t1_coll", 32'(collision), 32'd0);
    end
    do_reset();
    overlap();
    check("t2_ccnt1", 32'(collision_cnt), 32'd1);
    overlap();
    check("t2_ccnt2", 32'(collision_cnt), 32'd2);
    do_reset();
    for (int j = 0; j < 600 + DL + 2; j++) begin
      tx_en = (j < 600) ? 3'b001 : 3'b000;
      antena_out = (j < 600) ? 3'b001 : 3'b000;
      tick();
    end
    check("t3_ecnt", 32'(error_cnt), 32'(m_ecnt));
    do_reset();
    for (int j = 0; j < 40 + DL + 2; j++) begin
      tx_en = (j < 40) ? 3'b010 : 3'b000;
      antena_out = (j < 40) ? 3'({j[0], 1'b0}) : 3'b000;
      en = !(j >= 10 && j < 30);
      tick();
      if (!en) begin
        check("t4_ain", 32'(antena_in), 32'd0);
        check("t4_act", 32'(active_cnt), 32'd0);
      end
    end
    en = 1'b1;
    do_reset();
    for (int j = 0; j < DL; j++) begin
      tx_en = 3'b010;
      antena_out = 3'({j[0], 1'b0});
      tick();
    end
    do_reset();
    check("t5_ain", 32'(antena_in), 32'd0);
    check("t5_coll", 32'(collision), 32'd0);
    check("t5_act", 32'(active_cnt), 32'd0);
    for (int j = 0; j < DL + 2; j++) begin
      tick();
      check("t5_stale", 32'(antena_in), 32'd0);
    end
    do_reset();
    for (int j = 0; j < 600 + DL + 2; j++) begin
      tx_en = (j < 600 && j[0] == 1'b0) ? 3'b011 : 3'b000;
      antena_out = tx_en & 3'b001;
      tick();
    end
    check("t6_sat", 32'(collision_cnt), 32'hFF);
    tick();
    check("t6_hold", 32'(collision_cnt), 32'hFF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
